// File: rtl/dsp_div_signed_seq_active_low_async_reset.sv
// Sequential signed divider: radix-2 restoring on magnitudes, sign fix-up and
// quotient saturation afterwards. Fixed latency, start/done handshake.
module dsp_div_signed_seq_active_low_async_reset #(
  parameter int unsigned DIVIDEND_W = 38,
  parameter int unsigned DIVISOR_W  = 18,
  parameter int unsigned QUOT_W     = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W);
  localparam int unsigned MAG_W = DIVIDEND_W + 1;
  localparam int unsigned DM_W  = DIVISOR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [MAG_W-1:0]      quo_q, quo_d;
  logic [DM_W-1:0]       rem_q, rem_d;
  logic [DM_W-1:0]       dsr_q;
  logic                  sa_q, sb_q, zero_q;
  logic [QUOT_W-1:0]     res_q_q, res_q_d;
  logic [DIVISOR_W-1:0]  res_r_q, res_r_d;
  logic                  res_dz_q, res_ov_q, res_ov_d;

  logic [DM_W:0]         partial;
  logic                  ge;
  logic [MAG_W-1:0]      dvd_ext, dvd_mag, lim;
  logic [DM_W-1:0]       dsr_ext, dsr_mag;
  logic                  neg;
  logic [QUOT_W-1:0]     qt;
  logic [DIVISOR_W-1:0]  rt;

  always_comb begin
    partial = {rem_q, quo_q[DIVIDEND_W-1]};
    ge      = partial >= {1'b0, dsr_q};
    rem_d   = ge ? DM_W'(partial - {1'b0, dsr_q}) : partial[DM_W-1:0];
    quo_d   = {1'b0, quo_q[DIVIDEND_W-2:0], ge};

    // one extra magnitude bit keeps the most negative operands exact
    dvd_ext = {dividend[DIVIDEND_W-1], dividend};
    dvd_mag = dividend[DIVIDEND_W-1] ? (~dvd_ext + MAG_W'(1)) : dvd_ext;
    dsr_ext = {divisor[DIVISOR_W-1], divisor};
    dsr_mag = divisor[DIVISOR_W-1] ? (~dsr_ext + DM_W'(1)) : dsr_ext;

    neg = sa_q ^ sb_q;
    lim = neg ? (MAG_W'(1) << (QUOT_W-1))
              : ((MAG_W'(1) << (QUOT_W-1)) - MAG_W'(1));
    qt  = quo_q[QUOT_W-1:0];
    rt  = rem_q[DIVISOR_W-1:0];

    res_q_d  = neg ? (~qt + QUOT_W'(1)) : qt;
    res_r_d  = sa_q ? (~rt + DIVISOR_W'(1)) : rt;
    res_ov_d = 1'b0;
    if (zero_q) begin
      res_q_d = '0;
      res_r_d = '0;
    end else if (quo_q > lim) begin
      res_q_d  = neg ? {1'b1, {(QUOT_W-1){1'b0}}} : {1'b0, {(QUOT_W-1){1'b1}}};
      res_r_d  = '0;
      res_ov_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dsr_q       <= '0;
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      zero_q      <= 1'b0;
      res_q_q     <= '0;
      res_r_q     <= '0;
      res_dz_q    <= 1'b0;
      res_ov_q    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            quo_q   <= dvd_mag;
            rem_q   <= '0;
            dsr_q   <= dsr_mag;
            sa_q    <= dividend[DIVIDEND_W-1];
            sb_q    <= divisor[DIVISOR_W-1];
            zero_q  <= (divisor == '0);
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIVIDEND_W-1)) state_q <= S_FIX;
        end
        S_FIX: begin
          res_q_q  <= res_q_d;
          res_r_q  <= res_r_d;
          res_dz_q <= zero_q;
          res_ov_q <= res_ov_d;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          quotient    <= res_q_q;
          remainder   <= res_r_q;
          div_by_zero <= res_dz_q;
          overflow    <= res_ov_q;
          done        <= 1'b1;
          busy        <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_div_signed_seq_active_low_async_reset.sv
// Directed and round-trip checks of the sequential signed divider against a
// scoreboard of expected results pushed when each operation is issued.
module tb_dsp_div_signed_seq_active_low_async_reset;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [37:0] dividend;
  logic [17:0] divisor;
  logic        busy, done, div_by_zero, overflow;
  logic [19:0] quotient;
  logic [17:0] remainder;

  typedef struct {
    longint q;
    longint r;
    bit     dz;
    bit     ov;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   done_cnt    = 0;

  dsp_div_signed_seq_active_low_async_reset #(
    .DIVIDEND_W(38),
    .DIVISOR_W (18),
    .QUOT_W    (20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_res(input longint q, input longint r, input bit dz, input bit ov);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz; e.ov = ov;
    sb.push_back(e);
  endtask

  task automatic issue(input longint a, input longint b);
    dividend = a[37:0];
    divisor  = b[17:0];
    start    = 1'b1;
    tick();
    start    = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_quotient"},  $signed(quotient),  e.q);
      check({tag, "_remainder"}, $signed(remainder), e.r);
      check({tag, "_dbz"},       div_by_zero,        e.dz);
      check({tag, "_ovf"},       overflow,           e.ov);
    end
  endtask

  task automatic wait_done(input string tag, input int lat, input bit keep_start);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, lat);
    check({tag, "_busy_at_done"}, busy, 0);
    compare_result(tag);
    if (!keep_start) start = 1'b0;
    tick();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  task automatic roundtrip(input longint a, input longint b);
    longint ab, absb, off;
    ab   = a * b;
    absb = (b < 0) ? -b : b;
    off  = (ab > 0) ? (absb - 1) : ((ab < 0) ? -(absb - 1) : 0);
    expect_res(a, 0, 0, 0);
    issue(ab, b);
    wait_done("rt_exact", 40, 0);
    expect_res(a, off, 0, 0);
    issue(ab + off, b);
    wait_done("rt_rem", 40, 0);
  endtask

  initial begin
    logic signed [19:0] ar;
    logic signed [17:0] br;
    int c0, n;

    reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b1;
    tick();

    // Load non-zero outputs, then abort a run with an asynchronous reset
    expect_res(3, 1, 0, 0);
    issue(7, 2);
    wait_done("p7_p2", 40, 0);
    c0 = done_cnt;
    issue(1000, 7);
    repeat (10) tick();
    #3 reset = 1'b0;
    #1;
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (3) tick();
    check("abort_no_done", done_cnt - c0, 0);
    reset = 1'b1;
    tick();
    expect_res(5, 0, 0, 0);
    issue(10, 2);
    wait_done("p10_p2", 40, 0);
    check("p10_busy_after", busy, 0);

    // Sign combinations
    expect_res(-3, -1, 0, 0); issue(-7, 2);  wait_done("m7_p2", 40, 0);
    expect_res(-3,  1, 0, 0); issue(7, -2);  wait_done("p7_m2", 40, 0);
    expect_res( 3, -1, 0, 0); issue(-7, -2); wait_done("m7_m2", 40, 0);
    expect_res( 3,  1, 0, 0); issue(7, 2);   wait_done("p7_p2b", 40, 0);

    // Error and boundary cases
    expect_res(0, 0, 1, 0);            issue(123, 0);           wait_done("div0", 40, 0);
    expect_res(3, 0, 0, 0);            issue(9, 3);             wait_done("clr_dbz", 40, 0);
    expect_res(524287, 0, 0, 1);       issue(64'sd1 <<< 20, 1); wait_done("ovf_pos", 40, 0);
    expect_res(-524288, 0, 0, 1);      issue(-(64'sd1 <<< 20), 1); wait_done("ovf_neg", 40, 0);
    expect_res(-524288, 0, 0, 0);      issue(-524288, 1);       wait_done("exact_min", 40, 0);
    expect_res(524287, 0, 0, 1);       issue(-(64'sd1 <<< 37), -131072); wait_done("min_min", 40, 0);
    expect_res(-524288, 0, 0, 1);      issue(-(64'sd1 <<< 37), 1); wait_done("min_one", 40, 0);
    expect_res(3, 0, 0, 0);            issue(9, 3);             wait_done("clr_ovf", 40, 0);

    // Round trips: extremes, then random operands
    roundtrip(-524288, -131072);
    roundtrip(524287, 131071);
    roundtrip(-524288, 131071);
    for (int i = 0; i < 32; i++) begin
      ar = 20'($urandom);
      do br = 18'($urandom); while (br == 0);
      roundtrip(longint'(ar), longint'(br));
    end

    // start pulses while busy are ignored
    expect_res(166, 2, 0, 0);
    issue(500, 3);
    c0 = done_cnt;
    n  = 0;
    while (done !== 1'b1 && n < 200) begin
      if (n == 5 || n == 20) begin
        dividend = 38'd77; divisor = 18'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check("ignore_latency", n, 40);
    compare_result("ignore");
    repeat (45) tick();
    check("ignore_single_done", done_cnt - c0, 1);
    check("ignore_idle", busy, 0);
    check("ignore_hold_quotient", $signed(quotient), 166);

    // start held high: done every 41 clocks
    expect_res(-14, 2, 0, 0);
    expect_res(-14, 2, 0, 0);
    dividend = 38'd100;
    divisor  = -18'sd7;
    start    = 1'b1;
    tick();
    wait_done("held1", 40, 1);
    check("held_rearm_busy", busy, 1);
    wait_done("held2", 40, 0);
    check("held_sb_empty", sb.size(), 0);
    repeat (45) tick();
    check("held_stopped", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
